// File: rtl/board_sprite_scheduler.sv
// Per-pixel chessboard sprite scheduler.
// Tracks the square and in-square pixel under the VGA scan, holds the 64-square
// board state and emits the shared sprite ROM address together with the piece,
// pixel-on and square-colour flags, all registered two cycles after the pixel.
// Board writes are accepted only while the scan is in vertical blanking.
module board_sprite_scheduler #(
   parameter int BOARD_X0 = 100,
   parameter int BOARD_Y0 = 20,
   parameter int SQ       = 55
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        wr_valid,
   input  logic [5:0]  wr_square,
   input  logic [3:0]  wr_piece,
   output logic        wr_ready,
   output logic [15:0] rom_address,
   output logic [3:0]  piece_code,
   output logic        sprite_on,
   output logic        square_dark
);

   localparam int          PW           = $clog2(SQ);
   localparam logic [9:0]  X0           = 10'(BOARD_X0);
   localparam logic [9:0]  Y0           = 10'(BOARD_Y0);
   localparam logic [9:0]  VBLANK_LINE  = 10'd480;
   localparam logic [PW-1:0] SQ_LAST    = PW'(SQ - 1);
   localparam logic [15:0] SQ16         = 16'(SQ);
   localparam logic [15:0] SPRITE_WORDS = 16'(SQ * SQ);

   // Standard chess start position, indexed row*8+col from a8.
   function automatic logic [3:0] start_piece(input logic [5:0] sq);
      logic [3:0] back_black [8];
      logic [3:0] back_white [8];
      back_black = '{4'd12, 4'd10, 4'd11, 4'd13, 4'd14, 4'd11, 4'd10, 4'd12};
      back_white = '{4'd4,  4'd2,  4'd3,  4'd5,  4'd6,  4'd3,  4'd2,  4'd4};
      case (sq[5:3])
         3'd0:    return back_black[sq[2:0]];
         3'd1:    return 4'd9;
         3'd6:    return 4'd1;
         3'd7:    return back_white[sq[2:0]];
         default: return 4'd0;
      endcase
   endfunction

   // Only real piece codes are ever stored; anything else reads as empty.
   function automatic logic legal_piece(input logic [3:0] code);
      return ((code >= 4'd1) && (code <= 4'd6)) || ((code >= 4'd9) && (code <= 4'd14));
   endfunction

   logic [2:0]    col;
   logic [2:0]    row;
   logic [PW-1:0] px;
   logic [PW-1:0] py;
   logic          x_active;
   logic          y_active;
   logic [3:0]    board [64];

   logic [3:0]    cur_code;
   logic          cur_occ;
   logic [3:0]    sprite_idx;
   logic [15:0]   rom_calc;

   // Horizontal tracker: column and in-square pixel across the board width.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         col      <= 3'd0;
         px       <= '0;
         x_active <= 1'b0;
      end else if (DrawX == X0) begin
         col      <= 3'd0;
         px       <= '0;
         x_active <= 1'b1;
      end else if (x_active && (px == SQ_LAST)) begin
         px <= '0;
         if (col == 3'd7) begin
            x_active <= 1'b0;
         end else begin
            col <= col + 3'd1;
         end
      end else if (x_active) begin
         px <= px + 1'b1;
      end
   end

   // Vertical tracker: advances once per line, on the DrawX==0 cycle.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         row      <= 3'd0;
         py       <= '0;
         y_active <= 1'b0;
      end else if (DrawX == 10'd0) begin
         if (DrawY == Y0) begin
            row      <= 3'd0;
            py       <= '0;
            y_active <= 1'b1;
         end else if (y_active && (py == SQ_LAST)) begin
            py <= '0;
            if (row == 3'd7) begin
               y_active <= 1'b0;
            end else begin
               row <= row + 3'd1;
            end
         end else if (y_active) begin
            py <= py + 1'b1;
         end
      end
   end

   // Write window opens one cycle after the scan enters vertical blanking.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ready <= 1'b0;
      end else begin
         wr_ready <= (DrawY >= VBLANK_LINE);
      end
   end

   // Board state; illegal piece codes are stored as empty.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) begin
            board[i] <= start_piece(6'(i));
         end
      end else if (wr_valid && wr_ready) begin
         board[wr_square] <= legal_piece(wr_piece) ? wr_piece : 4'd0;
      end
   end

   // Board lookup and sprite address from the registered tracker state.
   always_comb begin
      cur_code   = board[{row, col}];
      cur_occ    = legal_piece(cur_code);
      sprite_idx = 4'd0;
      if (cur_code >= 4'd9) begin
         sprite_idx = cur_code - 4'd3;
      end else if (cur_code >= 4'd1) begin
         sprite_idx = cur_code - 4'd1;
      end
      rom_calc = (16'(sprite_idx) * SPRITE_WORDS) + 16'(px) + (16'(py) * SQ16);
   end

   // Output register: everything forced to zero outside the board.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address <= 16'd0;
         piece_code  <= 4'd0;
         sprite_on   <= 1'b0;
         square_dark <= 1'b0;
      end else if (x_active && y_active) begin
         square_dark <= row[0] ^ col[0];
         if (cur_occ) begin
            rom_address <= rom_calc;
            piece_code  <= cur_code;
            sprite_on   <= 1'b1;
         end else begin
            rom_address <= 16'd0;
            piece_code  <= 4'd0;
            sprite_on   <= 1'b0;
         end
      end else begin
         rom_address <= 16'd0;
         piece_code  <= 4'd0;
         sprite_on   <= 1'b0;
         square_dark <= 1'b0;
      end
   end

endmodule

// File: tb/tb_board_sprite_scheduler.sv
// Directed bench for board_sprite_scheduler: compressed frames where only a few
// lines are scanned pixel by pixel, other lines present just DrawX==0.
module tb_board_sprite_scheduler;

   logic        vga_clk;
   logic        reset_n;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        wr_valid;
   logic [5:0]  wr_square;
   logic [3:0]  wr_piece;
   logic        wr_ready;
   logic [15:0] rom_address;
   logic [3:0]  piece_code;
   logic        sprite_on;
   logic        square_dark;

   board_sprite_scheduler dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .wr_valid    (wr_valid),
      .wr_square   (wr_square),
      .wr_piece    (wr_piece),
      .wr_ready    (wr_ready),
      .rom_address (rom_address),
      .piece_code  (piece_code),
      .sprite_on   (sprite_on),
      .square_dark (square_dark)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int frame;
      int slot;
      int x;
      int addr;
      int piece;
      int on;
      int dark;
   } vec_t;

   localparam int NVEC = 19;
   vec_t tbl [NVEC];

   int n_vec;
   int n_fail;
   int acc_line;

   logic [15:0] cap_addr  [4][800];
   logic [3:0]  cap_piece [4][800];
   logic        cap_on    [4][800];
   logic        cap_dark  [4][800];

   function automatic int slot_of(input int y);
      case (y)
         20:      return 0;
         21:      return 1;
         243:     return 2;
         459:     return 3;
         default: return -1;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // One pixel clock: present (x,y), take the edge, sample 1 time unit later.
   task automatic step(input int x, input int y);
      logic will_acc;
      DrawX    = 10'(x);
      DrawY    = 10'(y);
      will_acc = wr_valid && wr_ready;
      @(posedge vga_clk);
      #1;
      if (will_acc) begin
         acc_line = y;
         wr_valid = 1'b0;
      end
   endtask

   // Full line sweep; outputs after the edge of pixel x belong to pixel x-1.
   task automatic scan_line(input int y, input int slot);
      for (int x = 0; x < 800; x++) begin
         step(x, y);
         if (x > 0) begin
            cap_addr[slot][x-1]  = rom_address;
            cap_piece[slot][x-1] = piece_code;
            cap_on[slot][x-1]    = sprite_on;
            cap_dark[slot][x-1]  = square_dark;
         end
      end
   endtask

   function automatic int count_on(input int slot);
      int n;
      n = 0;
      for (int x = 0; x < 799; x++) begin
         if (cap_on[slot][x]) n++;
      end
      return n;
   endfunction

   task automatic run_frame(input int f, input int wr_en, input int wr_line,
                            input int sq, input int pc, input int exp_acc,
                            input int rst_line);
      int slot;
      acc_line = -1;
      for (int y = 0; y < 525; y++) begin
         if ((wr_en != 0) && (y == wr_line)) begin
            wr_valid  = 1'b1;
            wr_square = 6'(sq);
            wr_piece  = 4'(pc);
         end
         if (y == rst_line) begin
            reset_n = 1'b0;
            #1;
            chk("midframe_reset_ready", int'(wr_ready), 0);
            chk("midframe_reset_addr", int'(rom_address), 0);
            repeat (3) step(0, y);
            reset_n = 1'b1;
         end
         slot = slot_of(y);
         if (slot >= 0) scan_line(y, slot);
         else           step(0, y);
         if (y == 0)   chk($sformatf("f%0d_ready_fall", f), int'(wr_ready), 0);
         if (y == 479) chk($sformatf("f%0d_ready_pre_vblank", f), int'(wr_ready), 0);
         if (y == 480) chk($sformatf("f%0d_ready_rise", f), int'(wr_ready), 1);
         if ((wr_en != 0) && (y == wr_line) && (y < 480))
            chk($sformatf("f%0d_ready_active_video", f), int'(wr_ready), 0);
      end
      if (wr_en != 0) chk($sformatf("f%0d_accept_line", f), acc_line, exp_acc);

      for (int i = 0; i < NVEC; i++) begin
         if (tbl[i].frame == f) begin
            int s;
            int x;
            s = tbl[i].slot;
            x = tbl[i].x;
            n_vec++;
            if ((int'(cap_addr[s][x]) != tbl[i].addr) || (int'(cap_piece[s][x]) != tbl[i].piece) ||
                (int'(cap_on[s][x]) != tbl[i].on) || (int'(cap_dark[s][x]) != tbl[i].dark)) begin
               n_fail++;
               $display("FAIL vec%0d f%0d (%0d,slot%0d): got addr=%0d piece=%0d on=%0d dark=%0d, want addr=%0d piece=%0d on=%0d dark=%0d",
                        i, f, x, s, cap_addr[s][x], cap_piece[s][x], cap_on[s][x], cap_dark[s][x],
                        tbl[i].addr, tbl[i].piece, tbl[i].on, tbl[i].dark);
            end
         end
      end
   endtask

   initial begin
      // frame, slot(20,21,243,459 -> 0..3), x, addr, piece, on, dark
      tbl[0]  = '{0, 0, 100, 27225, 12, 1, 0};
      tbl[1]  = '{0, 0,  99,     0,  0, 0, 0};
      tbl[2]  = '{0, 0, 540,     0,  0, 0, 0};
      tbl[3]  = '{0, 0, 154, 27279, 12, 1, 0};
      tbl[4]  = '{0, 0, 155, 21175, 10, 1, 1};
      tbl[5]  = '{0, 1, 156, 21231, 10, 1, 1};
      tbl[6]  = '{0, 3, 539, 12099,  4, 1, 0};
      tbl[7]  = '{0, 3, 100, 12045,  4, 1, 1};
      tbl[8]  = '{0, 2, 322,     0,  0, 0, 0};
      tbl[9]  = '{0, 2, 155,     0,  0, 0, 1};
      tbl[10] = '{1, 2, 322,   167,  1, 1, 0};
      tbl[11] = '{1, 0, 100, 27225, 12, 1, 0};
      tbl[12] = '{2, 0, 100,     0,  0, 0, 0};
      tbl[13] = '{2, 1, 156, 21231, 10, 1, 1};
      tbl[14] = '{2, 2, 322,     0,  0, 0, 0};
      tbl[15] = '{2, 3, 539,     0,  0, 0, 0};
      tbl[16] = '{3, 0, 100, 27225, 12, 1, 0};
      tbl[17] = '{3, 2, 322,     0,  0, 0, 0};
      tbl[18] = '{3, 1, 100, 27280, 12, 1, 0};

      n_vec     = 0;
      n_fail    = 0;
      acc_line  = -1;
      reset_n   = 1'b0;
      DrawX     = 10'd0;
      DrawY     = 10'd0;
      wr_valid  = 1'b0;
      wr_square = 6'd0;
      wr_piece  = 4'd0;

      #3;
      chk("reset_rom_address", int'(rom_address), 0);
      chk("reset_piece_code", int'(piece_code), 0);
      chk("reset_sprite_on", int'(sprite_on), 0);
      chk("reset_square_dark", int'(square_dark), 0);
      chk("reset_wr_ready", int'(wr_ready), 0);
      @(posedge vga_clk);
      @(posedge vga_clk);
      #1;
      reset_n = 1'b1;

      // Frame 0: start position; write held from active video, lands in vblank.
      run_frame(0, 1, 100, 36, 1, 481, -1);
      chk("f0_line459_on_pixels", count_on(3), 440);
      // Frame 1: written pawn visible; illegal code written to a8 at line 490.
      run_frame(1, 1, 490, 0, 7, 490, -1);
      // Frame 2: a8 empty; mid-frame reset blanks the rest of the frame.
      run_frame(2, 0, 0, 0, 0, 0, 200);
      chk("f2_line243_on_pixels", count_on(2), 0);
      chk("f2_line459_on_pixels", count_on(3), 0);
      // Frame 3: start position restored.
      run_frame(3, 0, 0, 0, 0, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/board_sprite_scheduler.md
# board_sprite_scheduler

Per-pixel scheduler that shares one combined 12-piece sprite ROM across all 64 board squares. It tracks which square and which in-square pixel the VGA scan is on and holds the 64-entry board-state register file. It emits the shared ROM address plus pixel-on, piece and square-colour flags, all aligned to a fixed latency. Game logic updates the board through a valid/ready write port that opens only during vertical blanking.

## Interface
- BOARD_X0, 100: left pixel column of square col 0.
- BOARD_Y0, 20: top pixel row of square row 0.
- SQ, 55: square edge in pixels; sprite ROM holds 12 sprites of SQ*SQ 4-bit pixels, piece-major.
- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX, DrawY  in  10  current scan pixel; DrawX advances by 1 per vga_clk, 0..799; DrawY changes when DrawX wraps to 0.
- wr_valid  in  1  board write request.
- wr_square  in  6  row*8+col; 0 = a8 (top-left), 63 = h1.
- wr_piece  in  4  0 empty; 1..6 white P N B R Q K; 9..14 black P N B R Q K.
- wr_ready  out  1  write accepted on posedge where wr_valid && wr_ready.
- rom_address  out  16  shared sprite ROM address.
- piece_code  out  4  piece on current square.
- sprite_on  out  1  pixel inside board and square occupied.
- square_dark  out  1  (row+col) odd, inside board.

## Operation
- Reset: board = standard start position: squares 0..7 = 12,10,11,13,14,11,10,12; 8..15 = 9; 16..47 = 0; 48..55 = 1; 56..63 = 4,2,3,5,6,3,2,4. All outputs 0; x_active = y_active = 0.
- X tracking, every cycle:
  - DrawX==BOARD_X0: col=0, px=0, x_active=1.
  - Else if x_active and px==SQ-1: px=0; if col==7 then x_active=0, else col++.
  - Else if x_active: px++.
- Y tracking, only on cycles with DrawX==0:
  - DrawY==BOARD_Y0: row=0, py=0, y_active=1.
  - Else if y_active and py==SQ-1: py=0; if row==7 then y_active=0, else row++.
  - Else if y_active: py++.
- Lookup stage, using the registered tracker state:
  - Board read at row*8+col.
  - Index mapping: codes 1..6 → idx 0..5; codes 9..14 → idx 6..11.
  - rom_address = idx*SQ*SQ + px + py*SQ, computed at 16-bit width, no truncation; max 11*3025+3024 = 36299.
- Output values:
  - Inside board (x_active && y_active) and occupied: sprite_on=1, piece_code = code, rom_address as above.
  - Inside board and empty: sprite_on=0, piece_code=0, rom_address=0.
  - Outside board: all outputs 0, including square_dark.
- Write port:
  - wr_ready is registered: wr_ready <= (DrawY >= 480).
  - On acceptance, board[wr_square] <= wr_piece. Illegal codes 7, 8 and 15 are stored as 0.
  - No write ever lands during active video, so no frame tearing.
- Reset mid-frame: trackers go inactive. Outputs stay 0 until the next DrawY==BOARD_Y0 line; x tracking restarts at the next DrawX==BOARD_X0. Board reverts to the start position.

## Timing
- Tracker registers update on the edge that samples DrawX/DrawY (T → state at T+1).
- Lookup results are registered at T+2. All four outputs are valid 2 cycles after the pixel is presented and mutually aligned.
- A write accepted at edge E is visible to lookups from E+1. It first affects output on the next frame.
- wr_ready lags DrawY by 1 cycle:
  - Rises 1 cycle after DrawY reaches 480.
  - Falls 1 cycle after DrawY wraps to 0.
- A request held across that falling edge is not accepted; the requester keeps wr_valid high until acceptance.
- wr_square and wr_piece must stay stable while wr_valid=1 and wr_ready=0.

## Test plan
- Reset, then scan pixel (100,20) → 2 cycles later: rom_address=27225, piece_code=12, sprite_on=1, square_dark=0.
- Pixel (156,21), black knight b8 → rom_address=21175+1+55=21231, piece_code=10, square_dark=1.
- Pixel (539,459), h1 → rom_address=12099, piece_code=4, square_dark=0; pixels (99,20) and (540,20) → sprite_on=0, rom_address=0, square_dark=0.
- Write port, with wr_valid held:
  - At DrawY=100 → wr_ready=0 and board unchanged.
  - At DrawY=490 → accepted; write wr_square=36, wr_piece=1.
  - Next frame, pixel (322,243) → rom_address=167, piece_code=1, sprite_on=1.
- Write of wr_piece=7 to square 0 during vblank → next frame (100,20): sprite_on=0, piece_code=0, square_dark=0.
- Assert reset_n low at DrawY=200 for 3 cycles → sprite_on=0 for the rest of the frame. Next frame, (100,20) → rom_address=27225, and square 36 is empty again.
